// File: rtl/ni_inject.sv
// ni_inject: PE-to-router injection stage.
// Two per-VC flit FIFOs, credit flow control, round-robin VC arbitration.
module ni_inject #(
   parameter int DEPTH   = 4,
   parameter int CREDITS = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [70:0]      in_flit,
   input  logic             in_send,
   output logic [1:0]       in_ready,
   output logic [70:0]      out_flit,
   output logic             out_valid,
   input  logic [1:0]       credit_in,
   output logic [CNT_W-1:0] drop_count,
   output logic             credit_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CREDITS + 1);

   logic [70:0]      r_mem [2][DEPTH];
   logic [AW:0]      r_wp  [2];
   logic [AW:0]      r_rp  [2];
   logic [CW-1:0]    r_cred[2];
   logic             r_last;
   logic [70:0]      r_flit;
   logic             r_valid;
   logic [CNT_W-1:0] r_drop;
   logic             r_err;

   logic [AW:0]      w_occ [2];
   logic [70:0]      w_head[2];
   logic [1:0]       w_full;
   logic [1:0]       w_elig;
   logic [1:0]       w_pop;
   logic [1:0]       w_push;
   logic             w_gnt_any;
   logic             w_gnt_vc;
   logic             w_in_vld;
   logic             w_tgt;
   logic             w_drop;

   // Occupancy, eligibility, arbitration and push/drop decisions.
   always_comb begin
      w_in_vld  = in_send & in_flit[70];
      w_tgt     = in_flit[64];
      for (int v = 0; v < 2; v++) begin
         w_occ[v]  = r_wp[v] - r_rp[v];
         w_head[v] = r_mem[v][r_rp[v][AW-1:0]];
         w_full[v] = (w_occ[v] == (AW+1)'(DEPTH));
         w_elig[v] = (w_occ[v] != '0) && (r_cred[v] != '0);
      end
      w_gnt_any = |w_elig;
      w_gnt_vc  = (&w_elig) ? ~r_last : w_elig[1];
      w_pop     = 2'b00;
      if (w_gnt_any) w_pop[w_gnt_vc] = 1'b1;
      w_push    = 2'b00;
      w_drop    = 1'b0;
      if (w_in_vld) begin
         if (!w_full[w_tgt] || w_pop[w_tgt]) w_push[w_tgt] = 1'b1;
         else                                w_drop         = 1'b1;
      end
   end

   // Flit storage; contents need no reset, pointers define validity.
   always_ff @(posedge clk) begin
      for (int v = 0; v < 2; v++)
         if (w_push[v]) r_mem[v][r_wp[v][AW-1:0]] <= in_flit;
   end

   // Pointers, credits, registered output and status counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < 2; v++) begin
            r_wp[v]   <= '0;
            r_rp[v]   <= '0;
            r_cred[v] <= CW'(CREDITS);
         end
         r_last  <= 1'b1;
         r_flit  <= '0;
         r_valid <= 1'b0;
         r_drop  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_gnt_any;
         if (w_gnt_any) begin
            r_flit <= w_head[w_gnt_vc];
            r_last <= w_gnt_vc;
         end
         for (int v = 0; v < 2; v++) begin
            if (w_push[v]) r_wp[v] <= r_wp[v] + (AW+1)'(1);
            if (w_pop[v])  r_rp[v] <= r_rp[v] + (AW+1)'(1);
            if (credit_in[v] && !w_pop[v]) begin
               if (r_cred[v] == CW'(CREDITS)) r_err <= 1'b1;
               else r_cred[v] <= r_cred[v] + CW'(1);
            end else if (!credit_in[v] && w_pop[v]) begin
               r_cred[v] <= r_cred[v] - CW'(1);
            end
         end
         if (w_drop && !(&r_drop)) r_drop <= r_drop + CNT_W'(1);
      end
   end

   assign in_ready   = ~w_full;
   assign out_flit   = r_flit;
   assign out_valid  = r_valid;
   assign drop_count = r_drop;
   assign credit_err = r_err;

endmodule
